// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix-multiply engine: C[ROWS][COLS] = A[ROWS][k] * W[k][COLS].
// Operands are skewed on entry, ripple right/down one PE per cycle, results drain one row per handshake.
module systolic_mm_engine #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int A_W    = 8,
  parameter int W_W    = 8,
  parameter int PSUM_W = 24,
  parameter int K_MAX  = 256,
  parameter int SAT    = 1,
  localparam int K_W   = $clog2(K_MAX + 1),
  localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic [ROWS-1:0]          row_mask,
  input  logic [COLS-1:0]          col_mask,
  output logic                     busy,
  output logic                     done,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ROWS*A_W-1:0]      a_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [COLS*W_W-1:0]      w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*PSUM_W-1:0]   out_data,
  output logic [R_W-1:0]           out_row,
  output logic                     out_last
);
  localparam int F_W = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [K_W-1:0]  k_q, beat_cnt;
  logic [ROWS-1:0] rmask;
  logic [COLS-1:0] cmask;
  logic [F_W-1:0]  flush_cnt;
  logic [R_W-1:0]  row_q;
  logic            start_ok, accept, last_beat, flush_end, last_row, out_hs, clr;

  assign start_ok  = start && (k_len != '0) && (k_len <= K_W'(K_MAX));
  assign accept    = (state == FEED) && a_valid && w_valid;
  assign last_beat = accept && (beat_cnt == k_q - 1'b1);
  assign flush_end = (flush_cnt == F_W'(ROWS + COLS - 2));
  assign last_row  = (row_q == R_W'(ROWS - 1));
  assign out_hs    = (state == DRAIN) && out_ready;
  assign clr       = (state == IDLE) && start_ok;
  assign out_row   = row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    a_ready   = 1'b0;
    w_ready   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = FEED;
      FEED: begin
        busy    = 1'b1;
        a_ready = w_valid;
        w_ready = a_valid;
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = last_row;
        if (out_ready && last_row) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      rmask     <= '0;
      cmask     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_q     <= '0;
      done      <= 1'b0;
    end else begin
      done <= out_hs && last_row;
      if (clr) begin
        k_q       <= k_len;
        rmask     <= row_mask;
        cmask     <= col_mask;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_q     <= '0;
      end
      if (accept) beat_cnt <= beat_cnt + 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (out_hs) row_q <= last_row ? '0 : row_q + 1'b1;
    end
  end

  // Activation entries carry the valid tag in the MSB; row r is delayed r cycles.
  logic [A_W:0]              a_row [ROWS];
  logic [W_W-1:0]            w_col [COLS];
  logic [A_W:0]              a_pe  [ROWS][COLS];
  logic [W_W-1:0]            w_pe  [ROWS][COLS];
  logic signed [PSUM_W-1:0]  acc   [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [A_W:0] a_in;
    assign a_in = {accept, a_data[r*A_W +: A_W]};
    if (r == 0) begin : g_direct
      assign a_row[r] = a_in;
    end else begin : g_dly
      logic [A_W:0] dly [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < r; i++) dly[i] <= '0;
        end else begin
          dly[0] <= a_in;
          for (int unsigned i = 1; i < r; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_row[r] = dly[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    logic [W_W-1:0] w_in;
    assign w_in = w_data[c*W_W +: W_W];
    if (c == 0) begin : g_direct
      assign w_col[c] = w_in;
    end else begin : g_dly
      logic [W_W-1:0] dly [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < c; i++) dly[i] <= '0;
        end else begin
          dly[0] <= w_in;
          for (int unsigned i = 1; i < c; i++) dly[i] <= dly[i-1];
        end
      end
      assign w_col[c] = dly[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic [A_W:0]               a_left, a_q;
      logic [W_W-1:0]             w_up, w_q;
      logic signed [PSUM_W-1:0]   acc_q, acc_nxt;
      logic signed [A_W+W_W-1:0]  prod;
      logic signed [PSUM_W:0]     sum;
      logic                       en;

      if (c == 0) begin : g_al
        assign a_left = a_row[r];
      end else begin : g_al
        assign a_left = a_pe[r][c-1];
      end
      if (r == 0) begin : g_wu
        assign w_up = w_col[c];
      end else begin : g_wu
        assign w_up = w_pe[r-1][c];
      end

      assign prod = $signed(a_q[A_W-1:0]) * $signed(w_q);
      assign sum  = (PSUM_W+1)'(acc_q) + (PSUM_W+1)'(prod);
      assign en   = a_q[A_W] & rmask[r] & cmask[c];

      // One guard bit is enough: a single product never exceeds the accumulator range.
      always_comb begin
        acc_nxt = sum[PSUM_W-1:0];
        if ((SAT != 0) && (sum[PSUM_W] != sum[PSUM_W-1]))
          acc_nxt = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          w_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= a_left;
          w_q <= w_up;
          if (clr)     acc_q <= '0;
          else if (en) acc_q <= acc_nxt;
        end
      end

      assign a_pe[r][c] = a_q;
      assign w_pe[r][c] = w_q;
      assign acc[r][c]  = acc_q;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN)
      for (int unsigned c = 0; c < COLS; c++) out_data[c*PSUM_W +: PSUM_W] = acc[row_q][c];
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: default 24-bit instance plus 20-bit saturating and wrapping instances
// sharing one stimulus stream.
module tb_systolic_mm_engine;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int K_W  = 9;

  logic         clk = 1'b0;
  logic         rst, start, a_valid, w_valid, out_ready;
  logic [K_W-1:0] k_len;
  logic [7:0]   row_mask, col_mask;
  logic [63:0]  a_data, w_data;

  logic         busy, done, a_ready, w_ready, out_valid, out_last;
  logic [2:0]   out_row;
  logic [191:0] out_data;
  logic         busy_s, done_s, a_ready_s, w_ready_s, out_valid_s, out_last_s;
  logic [2:0]   out_row_s;
  logic [159:0] out_data_s;
  logic         busy_w, done_w, a_ready_w, w_ready_w, out_valid_w, out_last_w;
  logic [2:0]   out_row_w;
  logic [159:0] out_data_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_mm_engine dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .row_mask(row_mask), .col_mask(col_mask),
    .busy(busy), .done(done), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_last(out_last));

  systolic_mm_engine #(.PSUM_W(20), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .row_mask(row_mask), .col_mask(col_mask),
    .busy(busy_s), .done(done_s), .a_valid(a_valid), .a_ready(a_ready_s), .a_data(a_data),
    .w_valid(w_valid), .w_ready(w_ready_s), .w_data(w_data), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_row(out_row_s), .out_last(out_last_s));

  systolic_mm_engine #(.PSUM_W(20), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .row_mask(row_mask), .col_mask(col_mask),
    .busy(busy_w), .done(done_w), .a_valid(a_valid), .a_ready(a_ready_w), .a_data(a_data),
    .w_valid(w_valid), .w_ready(w_ready_w), .w_data(w_data), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .out_row(out_row_w), .out_last(out_last_w));

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference accumulation of k identical products into a p-bit accumulator.
  function automatic logic [23:0] model(input int k, input int p, input bit s, input int prod);
    longint acc, hi, lo;
    logic [23:0] rv;
    hi  = (longint'(1) << (p - 1)) - 1;
    lo  = -hi - 1;
    acc = 0;
    for (int i = 0; i < k; i++) begin
      acc = acc + prod;
      if (s) begin
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end else begin
        acc = acc & ((longint'(1) << p) - 1);
        if (acc > hi) acc = acc - (longint'(1) << p);
      end
    end
    rv = acc[23:0];
    return rv & 24'((longint'(1) << p) - 1);
  endfunction

  task automatic run_job(input string nm, input int k, input logic [7:0] rm, input logic [7:0] cm,
                         input logic signed [7:0] a, input logic [63:0] w, input bit toggle, input int stall);
    logic [191:0] e24  [ROWS];
    logic [159:0] e20s [ROWS];
    logic [159:0] e20w [ROWS];
    logic [23:0]  t;
    logic         av, wv;
    int           prod, cyc, beats;
    for (int r = 0; r < ROWS; r++) begin
      e24[r] = '0; e20s[r] = '0; e20w[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        prod = int'(a) * int'($signed(w[c*8 +: 8]));
        if (rm[r] && cm[c]) begin
          t = model(k, 24, 1'b1, prod); e24[r][c*24 +: 24]  = t;
          t = model(k, 20, 1'b1, prod); e20s[r][c*20 +: 20] = t[19:0];
          t = model(k, 20, 1'b0, prod); e20w[r][c*20 +: 20] = t[19:0];
        end
      end
    end
    a_valid = 1'b0; w_valid = 1'b0;
    k_len = K_W'(k); row_mask = rm; col_mask = cm;
    a_data = {8{a}}; w_data = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; beats = 0;
    while (beats < k && cyc < k + 40) begin
      av = toggle ? cyc[0] : 1'b1;
      wv = toggle ? (cyc != 3) : 1'b1;
      a_valid = av; w_valid = wv;
      @(negedge clk);
      check({nm, " busy_feed"}, busy, 1'b1);
      check({nm, " a_ready"}, a_ready, wv);
      check({nm, " w_ready"}, w_ready, av);
      if (av && wv) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    a_valid = 1'b0; w_valid = 1'b0;
    out_ready = (stall == 0);
    while (cyc < k + 60) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " out_valid_seen"}, out_valid, 1'b1);
    if (!toggle) check({nm, " first_valid_cycle"}, cyc, k + ROWS + COLS);
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        for (int s = 0; s < stall; s++) begin
          check({nm, " stall_row"}, out_row, 3'd0);
          check({nm, " stall_data"}, out_data, e24[0]);
          check({nm, " stall_valid"}, out_valid, 1'b1);
          @(posedge clk); #1;
          if (s == stall - 1) out_ready = 1'b1;
          @(negedge clk);
        end
      end
      check({nm, " out_valid"}, out_valid, 1'b1);
      check({nm, " out_row"}, out_row, r[2:0]);
      check({nm, " out_last"}, out_last, (r == ROWS - 1));
      check({nm, " done_drain"}, done, 1'b0);
      check({nm, " data24"}, out_data, e24[r]);
      check({nm, " data20_sat"}, out_data_s, e20s[r]);
      check({nm, " data20_wrap"}, out_data_w, e20w[r]);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check({nm, " done_pulse"}, done, 1'b1);
    check({nm, " busy_end"}, busy, 1'b0);
    check({nm, " out_valid_end"}, out_valid, 1'b0);
    check({nm, " out_row_end"}, out_row, 3'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, " done_once"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; row_mask = '0; col_mask = '0; a_data = '0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_row", out_row, 3'd0);
    check("rst out_data", out_data, 192'd0);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range depths must leave the engine idle.
    k_len = 9'd0; row_mask = 8'hFF; col_mask = 8'hFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("k0 ignored", busy, 1'b0);
    k_len = 9'd300; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("k300 ignored", busy, 1'b0);

    run_job("k1_ramp", 1, 8'hFF, 8'hFF, 8'sd1, 64'h0807060504030201, 1'b0, 0);
    run_job("k3_cont", 3, 8'hFF, 8'hFF, 8'sd2, {8{8'd3}}, 1'b0, 0);
    run_job("k3_toggle", 3, 8'hFF, 8'hFF, 8'sd2, {8{8'd3}}, 1'b1, 0);
    // 64*127*127 = 1032256: clamps to 20'h7FFFF; below 2^20 so the wrap instance holds 20'hFC040.
    run_job("k64_sat", 64, 8'hFF, 8'hFF, 8'sd127, {8{8'd127}}, 1'b0, 0);
    run_job("mask_stall", 1, 8'h01, 8'h80, 8'sd1, 64'h0807060504030201, 1'b0, 5);
    run_job("signed", 2, 8'hFF, 8'hFF, -8'sd3, 64'h02FF0001807FFB05, 1'b0, 0);

    // Reset after two accepted beats of a k=3 job.
    k_len = 9'd3; row_mask = 8'hFF; col_mask = 8'hFF;
    a_data = {8{8'd2}}; w_data = {8{8'd3}};
    a_valid = 1'b1; w_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst a_ready", a_ready, 1'b0);
    check("midrst w_ready", w_ready, 1'b0);
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst out_data", out_data, 192'd0);
    check("midrst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_job("after_rst", 3, 8'hFF, 8'hFF, 8'sd2, {8{8'd3}}, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
